ahb_decoder_param: RTL and testbench

- Parametrised AHB address decoder for one master port of the bus matrix; SLAVE_NUM regions, each with an inclusive low/high bound.
- Generates address-phase slave requests and registered data-phase selects for the response mux.
- Contains an integrated default slave that returns the AHB two-cycle ERROR response for unmapped transfers.
- Supports a boot-remap mode and a saturating decode-error counter.

---
 rtl/ahb_decoder_param.sv | 158 +++++++++++++++
 tb/tb_ahb_decoder_param.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_decoder_param.sv
// AHB address decoder for one bus-matrix master port: region decode with
// lowest-index priority, optional boot remap, registered data-phase selects,
// an integrated two-cycle ERROR default slave and a saturating error counter.
module ahb_decoder_param #(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned SLAVE_NUM      = 4,
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] LOW_ADDR  = '0,
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] HIGH_ADDR = '0,
  parameter bit          REMAP_EN       = 1'b0,
  parameter logic [31:0] REMAP_SIZE     = 32'h0000_1000,
  parameter int unsigned REMAP_SLAVE    = 0,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]                htrans,
  input  logic                      hready,
  input  logic                      hremap,
  input  logic                      err_clr,
  output logic [SLAVE_NUM-1:0]      hreq,
  output logic                      default_slv_sel,
  output logic [SLAVE_NUM-1:0]      data_sel,
  output logic                      data_default_sel,
  output logic                      def_hready_out,
  output logic [1:0]                def_hresp,
  output logic [CNT_WIDTH-1:0]      err_cnt
);

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_ERR1 = 2'b01,
    D_ERR2 = 2'b10
  } def_state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // Remap window compare is done at the wider of address and REMAP_SIZE widths
  localparam int unsigned CMP_W = (AHB_ADDR_WIDTH > 32) ? AHB_ADDR_WIDTH : 32;

  logic                 active;
  logic                 remap_hit;
  logic                 match_found;
  logic [SLAVE_NUM-1:0] hit;

  logic [SLAVE_NUM-1:0] data_sel_q, data_sel_d;
  logic                 data_default_sel_q, data_default_sel_d;
  def_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic                 unmapped_accept;

  // Address-phase decode: remap window first, then lowest-index region match
  always_comb begin
    active      = (htrans == HT_NONSEQ) || (htrans == HT_SEQ);
    remap_hit   = REMAP_EN && hremap &&
                  (CMP_W'(haddr) < CMP_W'(REMAP_SIZE));
    match_found = 1'b0;
    hit         = '0;
    if (remap_hit) begin
      hit[REMAP_SLAVE] = 1'b1;
      match_found      = 1'b1;
    end else begin
      for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
        if (!match_found && (haddr >= LOW_ADDR[i]) && (haddr <= HIGH_ADDR[i])) begin
          hit[i]      = 1'b1;
          match_found = 1'b1;
        end
      end
    end
    hreq            = active ? hit : '0;
    default_slv_sel = active && !match_found;
    unmapped_accept = hready && default_slv_sel;
  end

  // Data-phase selects advance only when the bus accepts the address phase
  always_comb begin
    data_sel_d         = data_sel_q;
    data_default_sel_d = data_default_sel_q;
    if (hready) begin
      data_sel_d         = hreq;
      data_default_sel_d = default_slv_sel;
    end
  end

  // Default slave next-state: two-cycle ERROR, re-entered for back-to-back misses
  always_comb begin
    state_d = D_IDLE;
    unique case (state_q)
      D_IDLE:  state_d = unmapped_accept ? D_ERR1 : D_IDLE;
      D_ERR1:  state_d = D_ERR2;
      D_ERR2:  state_d = unmapped_accept ? D_ERR1 : D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  // Default slave response outputs
  always_comb begin
    def_hready_out = 1'b1;
    def_hresp      = RESP_OKAY;
    unique case (state_q)
      D_IDLE: begin
        def_hready_out = 1'b1;
        def_hresp      = RESP_OKAY;
      end
      D_ERR1: begin
        def_hready_out = 1'b0;
        def_hresp      = RESP_ERROR;
      end
      D_ERR2: begin
        def_hready_out = 1'b1;
        def_hresp      = RESP_ERROR;
      end
      default: begin
        def_hready_out = 1'b1;
        def_hresp      = RESP_OKAY;
      end
    endcase
  end

  // Saturating error counter; clear wins over increment
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (unmapped_accept && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      data_sel_q         <= '0;
      data_default_sel_q <= 1'b0;
      state_q            <= D_IDLE;
      err_cnt_q          <= '0;
    end else begin
      data_sel_q         <= data_sel_d;
      data_default_sel_q <= data_default_sel_d;
      state_q            <= state_d;
      err_cnt_q          <= err_cnt_d;
    end
  end

  assign data_sel         = data_sel_q;
  assign data_default_sel = data_default_sel_q;
  assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_ahb_decoder_param.sv
// Self-checking bench for ahb_decoder_param: two regions, remap to slave 1,
// 2-bit error counter. Reference model tracks the bus protocol abstractly.
module tb_ahb_decoder_param;

  localparam logic [31:0] REMAP_SZ  = 32'h0000_1000;
  localparam int          REMAP_SLV = 1;
  localparam int          CNT_MAX   = 3;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;
  logic        hremap;
  logic        err_clr;
  logic [1:0]  hreq;
  logic        default_slv_sel;
  logic [1:0]  data_sel;
  logic        data_default_sel;
  logic        def_hready_out;
  logic [1:0]  def_hresp;
  logic [1:0]  err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [1:0] m_dsel;
  logic       m_ddef;
  int         m_err_left;   // 0: no error response due, 2: first (wait) cycle, 1: second cycle
  int         m_cnt;

  logic [31:0] lo_tab [2];
  logic [31:0] hi_tab [2];

  always #5 hclk = ~hclk;

  ahb_decoder_param #(
    .AHB_ADDR_WIDTH (32),
    .SLAVE_NUM      (2),
    .LOW_ADDR       ({32'h0000_2500, 32'h0000_2000}),
    .HIGH_ADDR      ({32'h0000_2AFF, 32'h0000_24FF}),
    .REMAP_EN       (1'b1),
    .REMAP_SIZE     (REMAP_SZ),
    .REMAP_SLAVE    (REMAP_SLV),
    .CNT_WIDTH      (2)
  ) dut (
    .hclk             (hclk),
    .hreset_n         (hreset_n),
    .haddr            (haddr),
    .htrans           (htrans),
    .hready           (hready),
    .hremap           (hremap),
    .err_clr          (err_clr),
    .hreq             (hreq),
    .default_slv_sel  (default_slv_sel),
    .data_sel         (data_sel),
    .data_default_sel (data_default_sel),
    .def_hready_out   (def_hready_out),
    .def_hresp        (def_hresp),
    .err_cnt          (err_cnt)
  );

  // Target of a transfer: -1 no transfer, 0/1 slave, 2 unmapped
  function automatic int target(input logic [31:0] a, input logic [1:0] t, input logic rm);
    if (t == 2'b00 || t == 2'b01) return -1;
    if (rm && a < REMAP_SZ) return REMAP_SLV;
    for (int i = 0; i < 2; i++)
      if (a >= lo_tab[i] && a <= hi_tab[i]) return i;
    return 2;
  endfunction

  function automatic logic [1:0] exp_hreq(input int tg);
    if (tg == 0) return 2'b01;
    if (tg == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_def(input int tg);
    return tg == 2;
  endfunction

  function automatic logic exp_hready_out();
    return m_err_left != 2;
  endfunction

  function automatic logic [1:0] exp_hresp();
    return (m_err_left == 0) ? 2'b00 : 2'b01;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic rdy,
                       input logic rm, input logic clr);
    haddr = a; htrans = t; hready = rdy; hremap = rm; err_clr = clr;
    #1;
  endtask

  // Advance one clock and update the model from the inputs sampled at that edge
  task automatic tick();
    int tg;
    @(posedge hclk);
    tg = target(haddr, htrans, hremap);
    if (!hreset_n) begin
      m_dsel = 2'b00; m_ddef = 1'b0; m_err_left = 0; m_cnt = 0;
    end else begin
      if (m_err_left == 2) m_err_left = 1;
      else if (hready && tg == 2) m_err_left = 2;
      else m_err_left = 0;
      if (err_clr) m_cnt = 0;
      else if (hready && tg == 2 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (hready) begin
        m_dsel = exp_hreq(tg);
        m_ddef = exp_def(tg);
      end
    end
    @(negedge hclk);
  endtask

  task automatic test_reset();
    hreset_n = 1'b0;
    drive(32'h0000_3000, 2'b10, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    hreset_n = 1'b1;
    n_cmp++; if (data_sel !== 2'b00) begin n_fail++; $display("FAIL reset_data_sel got %b want 00", data_sel); end
    n_cmp++; if (data_default_sel !== 1'b0) begin n_fail++; $display("FAIL reset_data_def got %b want 0", data_default_sel); end
    n_cmp++; if (def_hready_out !== 1'b1) begin n_fail++; $display("FAIL reset_hready_out got %b want 1", def_hready_out); end
    n_cmp++; if (def_hresp !== 2'b00) begin n_fail++; $display("FAIL reset_hresp got %b want 00", def_hresp); end
    n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_decode();
    drive(32'h0000_2000, 2'b10, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (hreq !== 2'b01) begin n_fail++; $display("FAIL dec_2000 got %b want 01", hreq); end
    tick();
    drive(32'h0000_24FF, 2'b11, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (hreq !== 2'b01) begin n_fail++; $display("FAIL dec_24FF got %b want 01", hreq); end
    tick();
    drive(32'h0000_2AFF, 2'b10, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (hreq !== 2'b10) begin n_fail++; $display("FAIL dec_2AFF got %b want 10", hreq); end
    tick();
    drive(32'h0000_0000, 2'b00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (data_sel !== 2'b10) begin n_fail++; $display("FAIL dec_data_sel got %b want 10", data_sel); end
    // Boundary probes: comb only, no clock edge
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      case (k)
        0: a = 32'h0000_1FFF;
        1: a = 32'h0000_2500;
        2: a = 32'h0000_2B00;
        default: a = 32'hFFFF_FFFF;
      endcase
      drive(a, 2'b10, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({hreq, default_slv_sel} !== {exp_hreq(target(a, 2'b10, 1'b0)), exp_def(target(a, 2'b10, 1'b0))}) begin
        n_fail++; $display("FAIL dec_edge_%h got %b/%b", a, hreq, default_slv_sel);
      end
    end
    drive(32'h0000_2000, 2'b01, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({hreq, default_slv_sel} !== 3'b000) begin n_fail++; $display("FAIL dec_busy got %b/%b want 00/0", hreq, default_slv_sel); end
    tick();
  endtask

  task automatic test_default();
    drive(32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    tick();
    drive(32'h0000_3000, 2'b10, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (default_slv_sel !== 1'b1) begin n_fail++; $display("FAIL def_sel got %b want 1", default_slv_sel); end
    n_cmp++; if (hreq !== 2'b00) begin n_fail++; $display("FAIL def_hreq got %b want 00", hreq); end
    tick();
    drive(32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({def_hready_out, def_hresp} !== 3'b001) begin n_fail++; $display("FAIL def_err1 got %b/%b want 0/01", def_hready_out, def_hresp); end
    n_cmp++; if (data_default_sel !== 1'b1) begin n_fail++; $display("FAIL def_data_def got %b want 1", data_default_sel); end
    tick();
    drive(32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({def_hready_out, def_hresp} !== 3'b101) begin n_fail++; $display("FAIL def_err2 got %b/%b want 1/01", def_hready_out, def_hresp); end
    tick();
    n_cmp++; if ({def_hready_out, def_hresp} !== 3'b100) begin n_fail++; $display("FAIL def_okay got %b/%b want 1/00", def_hready_out, def_hresp); end
    n_cmp++; if (err_cnt !== 2'd1) begin n_fail++; $display("FAIL def_err_cnt got %0d want 1", err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] want [5];
    logic [31:0] a_tab [5];
    logic [1:0]  t_tab [5];
    logic        r_tab [5];
    want = '{3'b001, 3'b101, 3'b001, 3'b101, 3'b100};
    a_tab = '{32'h3004, 32'h3004, 32'h0, 32'h0, 32'h0};
    t_tab = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    r_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    drive(32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    tick();
    drive(32'h0000_3000, 2'b10, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({def_hready_out, def_hresp} !== want[k]) begin
        n_fail++; $display("FAIL b2b_step%0d got %b%b want %b", k, def_hready_out, def_hresp, want[k]);
      end
      drive(a_tab[k], t_tab[k], r_tab[k], 1'b0, 1'b0);
      tick();
    end
    n_cmp++; if (err_cnt !== 2'd2) begin n_fail++; $display("FAIL b2b_err_cnt got %0d want 2", err_cnt); end
  endtask

  task automatic test_hready_hold();
    drive(32'h0000_2600, 2'b10, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h0000_2100, 2'b10, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (data_sel !== 2'b10) begin n_fail++; $display("FAIL hold_cycle%0d got %b want 10", k, data_sel); end
    end
    drive(32'h0000_2100, 2'b10, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (data_sel !== 2'b01) begin n_fail++; $display("FAIL hold_release got %b want 01", data_sel); end
  endtask

  task automatic test_remap();
    drive(32'h0000_0800, 2'b10, 1'b0, 1'b1, 1'b0);
    n_cmp++; if ({hreq, default_slv_sel} !== 3'b100) begin n_fail++; $display("FAIL remap_on got %b/%b want 10/0", hreq, default_slv_sel); end
    drive(32'h0000_0FFF, 2'b11, 1'b0, 1'b1, 1'b0);
    n_cmp++; if ({hreq, default_slv_sel} !== 3'b100) begin n_fail++; $display("FAIL remap_top got %b/%b want 10/0", hreq, default_slv_sel); end
    drive(32'h0000_1000, 2'b10, 1'b0, 1'b1, 1'b0);
    n_cmp++; if ({hreq, default_slv_sel} !== 3'b001) begin n_fail++; $display("FAIL remap_past got %b/%b want 00/1", hreq, default_slv_sel); end
    drive(32'h0000_0800, 2'b10, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({hreq, default_slv_sel} !== 3'b001) begin n_fail++; $display("FAIL remap_off got %b/%b want 00/1", hreq, default_slv_sel); end
    drive(32'h0000_2000, 2'b10, 1'b0, 1'b1, 1'b0);
    n_cmp++; if ({hreq, default_slv_sel} !== 3'b010) begin n_fail++; $display("FAIL remap_region got %b/%b want 01/0", hreq, default_slv_sel); end
    tick();
  endtask

  task automatic test_saturate();
    drive(32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    tick(); tick(); tick();
    for (int k = 0; k < 5; k++) begin
      drive(32'h0000_3000 + 32'(4 * k), (k == 0) ? 2'b10 : 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
    end
    n_cmp++; if (err_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_err_cnt got %0d want 3", err_cnt); end
    drive(32'h0000_3100, 2'b10, 1'b1, 1'b0, 1'b1);
    tick();
    n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_clr_prio got %0d want 0", err_cnt); end
  endtask

  task automatic test_reset_mid();
    drive(32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    drive(32'h0000_2000, 2'b10, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h0000_3000, 2'b10, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (def_hready_out !== 1'b0) begin n_fail++; $display("FAIL rmid_in_err1 got %b want 0", def_hready_out); end
    hreset_n = 1'b0;
    drive(32'h0000_2000, 2'b10, 1'b1, 1'b0, 1'b0);
    tick();
    hreset_n = 1'b1;
    n_cmp++; if ({def_hready_out, def_hresp} !== 3'b100) begin n_fail++; $display("FAIL rmid_fsm got %b/%b want 1/00", def_hready_out, def_hresp); end
    n_cmp++; if ({data_sel, data_default_sel} !== 3'b000) begin n_fail++; $display("FAIL rmid_data got %b/%b want 00/0", data_sel, data_default_sel); end
    n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL rmid_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int tg;
      case ($urandom_range(0, 3))
        0: a = 32'h0000_2000 + 32'($urandom_range(0, 1)) * 32'h500 - 32'($urandom_range(0, 1));
        1: a = 32'h0000_2AFF + 32'($urandom_range(0, 1));
        2: a = 32'($urandom_range(0, 32'h3000));
        default: a = $urandom;
      endcase
      drive(a, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      tg = target(haddr, htrans, hremap);
      n_cmp++;
      if ({hreq, default_slv_sel} !== {exp_hreq(tg), exp_def(tg)}) begin
        n_fail++; $display("FAIL rnd_addr n=%0d a=%h got %b/%b want %b/%b", n, a, hreq, default_slv_sel, exp_hreq(tg), exp_def(tg));
      end
      tick();
      n_cmp++;
      if ({data_sel, data_default_sel} !== {m_dsel, m_ddef}) begin
        n_fail++; $display("FAIL rnd_data n=%0d got %b/%b want %b/%b", n, data_sel, data_default_sel, m_dsel, m_ddef);
      end
      n_cmp++;
      if ({def_hready_out, def_hresp} !== {exp_hready_out(), exp_hresp()}) begin
        n_fail++; $display("FAIL rnd_resp n=%0d got %b/%b want %b/%b", n, def_hready_out, def_hresp, exp_hready_out(), exp_hresp());
      end
      n_cmp++;
      if (err_cnt !== 2'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_cnt n=%0d got %0d want %0d", n, err_cnt, m_cnt);
      end
    end
  endtask

  initial begin
    lo_tab[0] = 32'h0000_2000; hi_tab[0] = 32'h0000_24FF;
    lo_tab[1] = 32'h0000_2500; hi_tab[1] = 32'h0000_2AFF;
    m_dsel = 2'b00; m_ddef = 1'b0; m_err_left = 0; m_cnt = 0;
    hreset_n = 1'b0;
    haddr = '0; htrans = 2'b00; hready = 1'b1; hremap = 1'b0; err_clr = 1'b0;
    @(negedge hclk);
    test_reset();
    test_decode();
    test_default();
    test_back_to_back();
    test_hready_hold();
    test_remap();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
